// File: rtl/bin_divider.sv
// bin_divider: sequential unsigned restoring divider, one quotient bit per clock.
//
// Computes quotient = num1 / num2 and remainder = num1 % num2 for WIDTH-bit operands.
// A start request is accepted whenever busy is low, which includes the DONE cycle, so
// divisions can run back to back. A zero divisor skips iteration and returns
// quotient = all ones, remainder = num1, div_by_zero = 1.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset; aborts any division in progress
//   start        division request, sampled only while busy is low
//   num1, num2   dividend and divisor, captured on the edge that accepts start
//   busy         high while iterating (CALC)
//   done         one-cycle pulse; results are valid from this cycle on
//   quotient     floor(num1 / num2)
//   remainder    num1 mod num2
//   div_by_zero  set when the accepted divisor was zero
//
// All outputs come straight from registers; there is no input-to-output path.

module bin_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;       // partial remainder, one guard bit for the trial
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend, shifted out MSB first
  logic [WIDTH-1:0] dvs_q, dvs_d;       // latched divisor
  logic [WIDTH-1:0] quo_q, quo_d;       // quotient shift register
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step: bring in the next dividend bit, try the subtraction, and keep
  // the result only if it did not go negative.
  always_comb begin
    shifted  = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    qbit     = ~trial[WIDTH];
    rem_next = qbit ? trial : shifted;
    quo_next = (quo_q << 1) | {{(WIDTH-1){1'b0}}, qbit};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      StCalc: begin
        rem_d = rem_next;
        dvd_d = dvd_q << 1;
        quo_d = quo_next;
        cnt_d = cnt_q - CntW'(1);
        // Last iteration: publish results on the same edge that enters DONE.
        if (cnt_q == CntW'(1)) begin
          state_d     = StDone;
          quotient_d  = quo_next;
          remainder_d = rem_next[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
      end

      // IDLE and DONE both accept a new request because busy is low in each.
      default: begin
        state_d = StIdle;
        if (start) begin
          dvd_d = num1;
          dvs_d = num2;
          rem_d = '0;
          quo_d = '0;
          cnt_d = CntW'(WIDTH);
          if (num2 != '0) begin
            state_d = StCalc;
          end else begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = num1;
            dbz_d       = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == StCalc);
  assign done        = (state_q == StDone);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_bin_divider.sv
// Self-checking bench for bin_divider: directed scenarios plus an exhaustive sweep and
// randomized back-to-back traffic, compared against plain integer division.

module tb_bin_divider;

  localparam int W = 4;
  localparam int MaxV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] num1, num2;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  bin_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num1       (num1),
    .num2       (num2),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish, got running want finished");
    $fatal(1);
  end

  // Reference model: plain integer division with the zero-divisor convention.
  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? MaxV : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int ref_lat(input int b);
    return (b == 0) ? 0 : W;
  endfunction

  // Issue one request (called at posedge+1) and return at posedge+1 of its done cycle.
  task automatic run_div(input int a, input int b, output int q, output int r,
                         output int z, output int lat, output int busy_cnt,
                         output int q_first, output bit hit);
    num1  = W'(a);
    num2  = W'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    q_first  = int'(quotient);
    lat      = 0;
    busy_cnt = 0;
    hit      = 1'b0;
    for (int i = 0; i < 4 * W + 8; i++) begin
      if (done) begin
        hit = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    q = int'(quotient);
    r = int'(remainder);
    z = int'(div_by_zero);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; num1 = W'(5); num2 = W'(2);
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++;
      $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done); end
    checks++; if ({quotient, remainder, div_by_zero} !== '0) begin errors++;
      $display("FAIL reset_outputs got q=%0d r=%0d z=%b want 0 0 0",
               quotient, remainder, div_by_zero); end
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy, done, quotient, remainder} !== '0) begin errors++;
      $display("FAIL reset_idle got busy=%b done=%b q=%0d r=%0d want all 0",
               busy, done, quotient, remainder); end
  endtask

  task automatic test_basic();
    int q, r, z, lat, bc, qf; bit hit;
    run_div(13, 3, q, r, z, lat, bc, qf, hit);
    checks++; if (!hit) begin errors++; $display("FAIL basic_done got none want pulse"); end
    checks++; if (bc != W) begin errors++;
      $display("FAIL basic_busy_cycles got %0d want %0d", bc, W); end
    checks++; if (lat != W) begin errors++;
      $display("FAIL basic_latency got %0d want %0d", lat, W); end
    checks++; if (q != 4 || r != 1 || z != 0) begin errors++;
      $display("FAIL basic_result got q=%0d r=%0d z=%0d want 4 1 0", q, r, z); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL basic_done_width got %b want 0", done); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (quotient !== W'(4) || remainder !== W'(1)) begin errors++;
      $display("FAIL basic_hold got q=%0d r=%0d want 4 1", quotient, remainder); end
  endtask

  task automatic test_back_to_back();
    int q, r, z, lat, bc, qf; bit hit;
    run_div(15, 1, q, r, z, lat, bc, qf, hit);
    checks++; if (!hit || q != 15 || r != 0 || z != 0) begin errors++;
      $display("FAIL b2b_first got hit=%0d q=%0d r=%0d z=%0d want 1 15 0 0", hit, q, r, z); end
    // Second request presented during the DONE cycle of the first.
    run_div(2, 9, q, r, z, lat, bc, qf, hit);
    checks++; if (qf != 15) begin errors++;
      $display("FAIL b2b_hold_during_calc got q=%0d want 15", qf); end
    checks++; if (!hit || lat != W) begin errors++;
      $display("FAIL b2b_gap got hit=%0d lat=%0d want 1 %0d", hit, lat, W); end
    checks++; if (q != 0 || r != 2 || z != 0) begin errors++;
      $display("FAIL b2b_second got q=%0d r=%0d z=%0d want 0 2 0", q, r, z); end
  endtask

  task automatic test_div_zero();
    int q, r, z, lat, bc, qf; bit hit;
    @(posedge clk); #1;
    run_div(7, 0, q, r, z, lat, bc, qf, hit);
    checks++; if (!hit || lat != 0 || bc != 0) begin errors++;
      $display("FAIL dbz_latency got hit=%0d lat=%0d busy=%0d want 1 0 0", hit, lat, bc); end
    checks++; if (q != MaxV || r != 7 || z != 1) begin errors++;
      $display("FAIL dbz_result got q=%0d r=%0d z=%0d want %0d 7 1", q, r, z, MaxV); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || div_by_zero !== 1'b1) begin errors++;
      $display("FAIL dbz_hold got done=%b z=%b want 0 1", done, div_by_zero); end
    run_div(6, 2, q, r, z, lat, bc, qf, hit);
    checks++; if (!hit || q != 3 || r != 0 || z != 0) begin errors++;
      $display("FAIL dbz_clear got hit=%0d q=%0d r=%0d z=%0d want 1 3 0 0", hit, q, r, z); end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    int q = -1, r = -1;
    @(posedge clk); #1;
    num1 = W'(12); num2 = W'(5); start = 1'b1;
    @(posedge clk); #1;
    num1 = W'(9); num2 = W'(2);
    repeat (W / 2) @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3 * W + 6; i++) begin
      if (done) begin
        if (pulses == 0) begin q = int'(quotient); r = int'(remainder); end
        pulses++;
      end
      @(posedge clk); #1;
    end
    checks++; if (pulses != 1) begin errors++;
      $display("FAIL ignore_pulses got %0d want 1", pulses); end
    checks++; if (q != 2 || r != 2) begin errors++;
      $display("FAIL ignore_result got q=%0d r=%0d want 2 2", q, r); end
  endtask

  task automatic test_abort();
    int pulses = 0;
    num1 = W'(14); num2 = W'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++;
      $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done); end
    checks++; if ({quotient, remainder, div_by_zero} !== '0) begin errors++;
      $display("FAIL abort_outputs got q=%0d r=%0d z=%b want 0 0 0",
               quotient, remainder, div_by_zero); end
    for (int i = 0; i < 2 * W + 4; i++) begin
      if (done || busy) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses != 0) begin errors++;
      $display("FAIL abort_no_done got %0d active cycles want 0", pulses); end
  endtask

  task automatic test_sweep();
    int q, r, z, lat, bc, qf; bit hit;
    for (int a = 0; a <= MaxV; a++) begin
      for (int b = 0; b <= MaxV; b++) begin
        run_div(a, b, q, r, z, lat, bc, qf, hit);
        checks++; if (!hit || lat != ref_lat(b)) begin errors++;
          $display("FAIL sweep_latency %0d/%0d got hit=%0d lat=%0d want 1 %0d",
                   a, b, hit, lat, ref_lat(b)); end
        checks++; if (q != ref_q(a, b) || r != ref_r(a, b) || z != int'(b == 0)) begin
          errors++;
          $display("FAIL sweep_result %0d/%0d got q=%0d r=%0d z=%0d want %0d %0d %0d",
                   a, b, q, r, z, ref_q(a, b), ref_r(a, b), int'(b == 0)); end
      end
    end
  endtask

  task automatic test_random();
    int q, r, z, lat, bc, qf, a, b; bit hit;
    int prev_q = int'(quotient);
    for (int n = 0; n < 60; n++) begin
      a = int'($urandom_range(MaxV, 0));
      b = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(MaxV, 1));
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #0;
      if (!done && !busy) prev_q = int'(quotient);
      run_div(a, b, q, r, z, lat, bc, qf, hit);
      if (b != 0) begin
        checks++; if (qf != prev_q) begin errors++;
          $display("FAIL rand_hold got q=%0d want %0d", qf, prev_q); end
        checks++; if (q * b + r != a || r >= b) begin errors++;
          $display("FAIL rand_invariant %0d/%0d got q=%0d r=%0d", a, b, q, r); end
      end
      checks++; if (!hit || q != ref_q(a, b) || r != ref_r(a, b) || z != int'(b == 0)) begin
        errors++;
        $display("FAIL rand_result %0d/%0d got q=%0d r=%0d z=%0d want %0d %0d %0d",
                 a, b, q, r, z, ref_q(a, b), ref_r(a, b), int'(b == 0)); end
      prev_q = q;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num1 = '0; num2 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_abort();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
